// File: rtl/ds_dispatch_queue_pkg.sv
// Shared widths and the dispatch FIFO entry layout.
package dispatch_pkg;

   localparam int unsigned ALUOP_W = 9;
   localparam int unsigned AREG_W  = 5;
   localparam int unsigned PREG_W  = 6;
   localparam int unsigned IMM_W   = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned NSLOT   = 4;

   // One dispatched instruction (106 bits).
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [ALUOP_W-1:0] aluop;
      logic [AREG_W-1:0]  src1;
      logic [AREG_W-1:0]  src2;
      logic [AREG_W-1:0]  rdst;
      logic [PREG_W-1:0]  rsrc1;
      logic [PREG_W-1:0]  rsrc2;
      logic [PREG_W-1:0]  phydst;
      logic [IMM_W-1:0]   imm;
   } dq_entry_t;

endpackage

// File: rtl/ds_dispatch_queue_if.sv
// Rename->dispatch bundle, stall back-pressure and the two issue ports.
interface ds_dispatch_queue_if #(
   parameter int unsigned DEPTH = 16
);
   import dispatch_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]    DS_Inst_PC;

   logic               DS_Inst1_Valid, DS_Inst2_Valid, DS_Inst3_Valid, DS_Inst4_Valid;
   logic [ALUOP_W-1:0] DS_Inst1_ALUop, DS_Inst2_ALUop, DS_Inst3_ALUop, DS_Inst4_ALUop;
   logic [AREG_W-1:0]  DS_Inst1_Src1, DS_Inst2_Src1, DS_Inst3_Src1, DS_Inst4_Src1;
   logic [AREG_W-1:0]  DS_Inst1_Src2, DS_Inst2_Src2, DS_Inst3_Src2, DS_Inst4_Src2;
   logic [AREG_W-1:0]  DS_Inst1_Rdst, DS_Inst2_Rdst, DS_Inst3_Rdst, DS_Inst4_Rdst;
   logic [PREG_W-1:0]  DS_Inst1_RSrc1, DS_Inst2_RSrc1, DS_Inst3_RSrc1, DS_Inst4_RSrc1;
   logic [PREG_W-1:0]  DS_Inst1_RSrc2, DS_Inst2_RSrc2, DS_Inst3_RSrc2, DS_Inst4_RSrc2;
   logic [PREG_W-1:0]  DS_Inst1_Phydst, DS_Inst2_Phydst, DS_Inst3_Phydst, DS_Inst4_Phydst;
   logic [IMM_W-1:0]   DS_Inst1_imm, DS_Inst2_imm, DS_Inst3_imm, DS_Inst4_imm;

   logic               Stall;
   logic [CW-1:0]      Count;

   logic               IS0_Valid, IS1_Valid, IS0_Ready, IS1_Ready;
   logic [PC_W-1:0]    IS0_PC, IS1_PC;
   logic [ALUOP_W-1:0] IS0_ALUop, IS1_ALUop;
   logic [AREG_W-1:0]  IS0_Src1, IS1_Src1, IS0_Src2, IS1_Src2, IS0_Rdst, IS1_Rdst;
   logic [PREG_W-1:0]  IS0_RSrc1, IS1_RSrc1, IS0_RSrc2, IS1_RSrc2, IS0_Phydst, IS1_Phydst;
   logic [IMM_W-1:0]   IS0_imm, IS1_imm;

   // Queue side
   modport slave (
      input  DS_Inst_PC,
      input  DS_Inst1_Valid, DS_Inst2_Valid, DS_Inst3_Valid, DS_Inst4_Valid,
      input  DS_Inst1_ALUop, DS_Inst2_ALUop, DS_Inst3_ALUop, DS_Inst4_ALUop,
      input  DS_Inst1_Src1, DS_Inst2_Src1, DS_Inst3_Src1, DS_Inst4_Src1,
      input  DS_Inst1_Src2, DS_Inst2_Src2, DS_Inst3_Src2, DS_Inst4_Src2,
      input  DS_Inst1_Rdst, DS_Inst2_Rdst, DS_Inst3_Rdst, DS_Inst4_Rdst,
      input  DS_Inst1_RSrc1, DS_Inst2_RSrc1, DS_Inst3_RSrc1, DS_Inst4_RSrc1,
      input  DS_Inst1_RSrc2, DS_Inst2_RSrc2, DS_Inst3_RSrc2, DS_Inst4_RSrc2,
      input  DS_Inst1_Phydst, DS_Inst2_Phydst, DS_Inst3_Phydst, DS_Inst4_Phydst,
      input  DS_Inst1_imm, DS_Inst2_imm, DS_Inst3_imm, DS_Inst4_imm,
      input  IS0_Ready, IS1_Ready,
      output Stall, Count, IS0_Valid, IS1_Valid,
      output IS0_PC, IS1_PC, IS0_ALUop, IS1_ALUop,
      output IS0_Src1, IS1_Src1, IS0_Src2, IS1_Src2, IS0_Rdst, IS1_Rdst,
      output IS0_RSrc1, IS1_RSrc1, IS0_RSrc2, IS1_RSrc2, IS0_Phydst, IS1_Phydst,
      output IS0_imm, IS1_imm
   );

   // Rename register / issue side
   modport master (
      output DS_Inst_PC,
      output DS_Inst1_Valid, DS_Inst2_Valid, DS_Inst3_Valid, DS_Inst4_Valid,
      output DS_Inst1_ALUop, DS_Inst2_ALUop, DS_Inst3_ALUop, DS_Inst4_ALUop,
      output DS_Inst1_Src1, DS_Inst2_Src1, DS_Inst3_Src1, DS_Inst4_Src1,
      output DS_Inst1_Src2, DS_Inst2_Src2, DS_Inst3_Src2, DS_Inst4_Src2,
      output DS_Inst1_Rdst, DS_Inst2_Rdst, DS_Inst3_Rdst, DS_Inst4_Rdst,
      output DS_Inst1_RSrc1, DS_Inst2_RSrc1, DS_Inst3_RSrc1, DS_Inst4_RSrc1,
      output DS_Inst1_RSrc2, DS_Inst2_RSrc2, DS_Inst3_RSrc2, DS_Inst4_RSrc2,
      output DS_Inst1_Phydst, DS_Inst2_Phydst, DS_Inst3_Phydst, DS_Inst4_Phydst,
      output DS_Inst1_imm, DS_Inst2_imm, DS_Inst3_imm, DS_Inst4_imm,
      output IS0_Ready, IS1_Ready,
      input  Stall, Count, IS0_Valid, IS1_Valid,
      input  IS0_PC, IS1_PC, IS0_ALUop, IS1_ALUop,
      input  IS0_Src1, IS1_Src1, IS0_Src2, IS1_Src2, IS0_Rdst, IS1_Rdst,
      input  IS0_RSrc1, IS1_RSrc1, IS0_RSrc2, IS1_RSrc2, IS0_Phydst, IS1_Phydst,
      input  IS0_imm, IS1_imm
   );

endinterface

// File: rtl/dq_compact.sv
// 4-slot packer: valid count and per-slot write offset (prefix popcount of lower slots).
module dq_compact (
   input  logic [3:0]      valid_i,
   output logic [2:0]      nv_o,
   output logic [3:0][1:0] offset_o
);

   logic [2:0] acc;

   // Running prefix sum; slot k lands after every valid slot below it.
   always_comb begin
      acc      = '0;
      offset_o = '0;
      for (int k = 0; k < 4; k++) begin
         offset_o[k] = acc[1:0];
         acc         = acc + {2'b00, valid_i[k]};
      end
      nv_o = acc;
   end

endmodule

// File: rtl/ds_dispatch_queue.sv
// In-order dispatch FIFO: packs a 4-wide rename bundle, drains up to two entries per cycle.
module ds_dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned PC_STEP = 4
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 flush,
   ds_dispatch_queue_if.slave  bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   dq_entry_t         mem_q [DEPTH];
   dq_entry_t         mem_d [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d, head1;
   logic [CW-1:0]     count_q, count_d, room;

   logic [3:0]        slot_valid;
   dq_entry_t         slot_e [4];
   logic [2:0]        nv;
   logic [3:0][1:0]   slot_off;
   logic [PC_W-1:0]   pc_step;
   logic              stall, accept, is0_valid, is1_valid, pop0, pop1;
   dq_entry_t         e0, e1;

   // Gather the bundle into entry form; slot PCs are derived from the bundle PC.
   always_comb begin
      pc_step    = PC_W'(PC_STEP);
      slot_valid = {bus.DS_Inst4_Valid, bus.DS_Inst3_Valid, bus.DS_Inst2_Valid,
                    bus.DS_Inst1_Valid};
      slot_e[0]  = '{pc: bus.DS_Inst_PC, aluop: bus.DS_Inst1_ALUop,
                     src1: bus.DS_Inst1_Src1, src2: bus.DS_Inst1_Src2, rdst: bus.DS_Inst1_Rdst,
                     rsrc1: bus.DS_Inst1_RSrc1, rsrc2: bus.DS_Inst1_RSrc2,
                     phydst: bus.DS_Inst1_Phydst, imm: bus.DS_Inst1_imm};
      slot_e[1]  = '{pc: bus.DS_Inst_PC + pc_step, aluop: bus.DS_Inst2_ALUop,
                     src1: bus.DS_Inst2_Src1, src2: bus.DS_Inst2_Src2, rdst: bus.DS_Inst2_Rdst,
                     rsrc1: bus.DS_Inst2_RSrc1, rsrc2: bus.DS_Inst2_RSrc2,
                     phydst: bus.DS_Inst2_Phydst, imm: bus.DS_Inst2_imm};
      slot_e[2]  = '{pc: bus.DS_Inst_PC + (pc_step << 1), aluop: bus.DS_Inst3_ALUop,
                     src1: bus.DS_Inst3_Src1, src2: bus.DS_Inst3_Src2, rdst: bus.DS_Inst3_Rdst,
                     rsrc1: bus.DS_Inst3_RSrc1, rsrc2: bus.DS_Inst3_RSrc2,
                     phydst: bus.DS_Inst3_Phydst, imm: bus.DS_Inst3_imm};
      slot_e[3]  = '{pc: bus.DS_Inst_PC + pc_step + (pc_step << 1), aluop: bus.DS_Inst4_ALUop,
                     src1: bus.DS_Inst4_Src1, src2: bus.DS_Inst4_Src2, rdst: bus.DS_Inst4_Rdst,
                     rsrc1: bus.DS_Inst4_RSrc1, rsrc2: bus.DS_Inst4_RSrc2,
                     phydst: bus.DS_Inst4_Phydst, imm: bus.DS_Inst4_imm};
   end

   dq_compact u_compact (
      .valid_i  (slot_valid),
      .nv_o     (nv),
      .offset_o (slot_off)
   );

   // Whole-bundle admission against start-of-cycle occupancy; pops never make room early.
   always_comb begin
      room      = CW'(DEPTH) - count_q;
      stall     = (CW'(nv) > room) & ~flush;
      accept    = ~stall & ~flush & (nv != 3'd0);
      is0_valid = (count_q != '0);
      is1_valid = (count_q > CW'(1));
      pop0      = is0_valid & bus.IS0_Ready & ~flush;
      pop1      = pop0 & is1_valid & bus.IS1_Ready;
   end

   // Next-state: packed writes at tail, in-order pops at head, flush clears pointers.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < 4; k++) begin
               if (slot_valid[k]) begin
                  mem_d[tail_q + PW'(slot_off[k])] = slot_e[k];
               end
            end
            tail_d = tail_q + PW'(nv);
         end
         head_d  = head_q + PW'(pop0) + PW'(pop1);
         count_d = count_q + (accept ? CW'(nv) : CW'(0)) - CW'(pop0) - CW'(pop1);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   // Issue ports present head and head+1.
   always_comb begin
      head1          = head_q + PW'(1);
      e0             = mem_q[head_q];
      e1             = mem_q[head1];
      bus.Stall      = stall;
      bus.Count      = count_q;
      bus.IS0_Valid  = is0_valid;
      bus.IS1_Valid  = is1_valid;
      bus.IS0_PC     = e0.pc;
      bus.IS0_ALUop  = e0.aluop;
      bus.IS0_Src1   = e0.src1;
      bus.IS0_Src2   = e0.src2;
      bus.IS0_Rdst   = e0.rdst;
      bus.IS0_RSrc1  = e0.rsrc1;
      bus.IS0_RSrc2  = e0.rsrc2;
      bus.IS0_Phydst = e0.phydst;
      bus.IS0_imm    = e0.imm;
      bus.IS1_PC     = e1.pc;
      bus.IS1_ALUop  = e1.aluop;
      bus.IS1_Src1   = e1.src1;
      bus.IS1_Src2   = e1.src2;
      bus.IS1_Rdst   = e1.rdst;
      bus.IS1_RSrc1  = e1.rsrc1;
      bus.IS1_RSrc2  = e1.rsrc2;
      bus.IS1_Phydst = e1.phydst;
      bus.IS1_imm    = e1.imm;
   end

endmodule

// File: tb/tb_ds_dispatch_queue.sv
// Directed bench for the dispatch queue: reset, packing, order, full/stall, flush, wrap.
module tb_ds_dispatch_queue;

   logic clk, rst, flush;
   int   n_cmp, n_fail;

   ds_dispatch_queue_if #(.DEPTH(16)) bus ();

   ds_dispatch_queue #(.DEPTH(16), .PC_STEP(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload fields are distinct functions of the slot's Rdst so crossed wiring shows up.
   function automatic logic [8:0]  f_alu(input logic [4:0] r); return 9'h100 | {4'b0, r}; endfunction
   function automatic logic [4:0]  f_s1(input logic [4:0] r);  return r ^ 5'h01; endfunction
   function automatic logic [4:0]  f_s2(input logic [4:0] r);  return r ^ 5'h02; endfunction
   function automatic logic [5:0]  f_rs1(input logic [4:0] r); return {1'b0, r} ^ 6'h15; endfunction
   function automatic logic [5:0]  f_rs2(input logic [4:0] r); return {1'b0, r} ^ 6'h2A; endfunction
   function automatic logic [5:0]  f_phy(input logic [4:0] r); return {1'b1, r}; endfunction
   function automatic logic [31:0] f_imm(input logic [4:0] r); return 32'hCAFE_0000 | {27'b0, r}; endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int k, input logic v, input logic [4:0] r);
      case (k)
         1: begin
            bus.DS_Inst1_Valid = v; bus.DS_Inst1_ALUop = f_alu(r); bus.DS_Inst1_Rdst = r;
            bus.DS_Inst1_Src1 = f_s1(r); bus.DS_Inst1_Src2 = f_s2(r); bus.DS_Inst1_RSrc1 = f_rs1(r);
            bus.DS_Inst1_RSrc2 = f_rs2(r); bus.DS_Inst1_Phydst = f_phy(r); bus.DS_Inst1_imm = f_imm(r);
         end
         2: begin
            bus.DS_Inst2_Valid = v; bus.DS_Inst2_ALUop = f_alu(r); bus.DS_Inst2_Rdst = r;
            bus.DS_Inst2_Src1 = f_s1(r); bus.DS_Inst2_Src2 = f_s2(r); bus.DS_Inst2_RSrc1 = f_rs1(r);
            bus.DS_Inst2_RSrc2 = f_rs2(r); bus.DS_Inst2_Phydst = f_phy(r); bus.DS_Inst2_imm = f_imm(r);
         end
         3: begin
            bus.DS_Inst3_Valid = v; bus.DS_Inst3_ALUop = f_alu(r); bus.DS_Inst3_Rdst = r;
            bus.DS_Inst3_Src1 = f_s1(r); bus.DS_Inst3_Src2 = f_s2(r); bus.DS_Inst3_RSrc1 = f_rs1(r);
            bus.DS_Inst3_RSrc2 = f_rs2(r); bus.DS_Inst3_Phydst = f_phy(r); bus.DS_Inst3_imm = f_imm(r);
         end
         default: begin
            bus.DS_Inst4_Valid = v; bus.DS_Inst4_ALUop = f_alu(r); bus.DS_Inst4_Rdst = r;
            bus.DS_Inst4_Src1 = f_s1(r); bus.DS_Inst4_Src2 = f_s2(r); bus.DS_Inst4_RSrc1 = f_rs1(r);
            bus.DS_Inst4_RSrc2 = f_rs2(r); bus.DS_Inst4_Phydst = f_phy(r); bus.DS_Inst4_imm = f_imm(r);
         end
      endcase
   endtask

   // v[0] is slot 1.
   task automatic set_bundle(input logic [31:0] pc, input logic [3:0] v, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] r3, input logic [4:0] r4);
      bus.DS_Inst_PC = pc;
      set_slot(1, v[0], r1);
      set_slot(2, v[1], r2);
      set_slot(3, v[2], r3);
      set_slot(4, v[3], r4);
   endtask

   task automatic clear_bundle();
      set_bundle(32'h0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      set_bundle(32'h100, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
      #3;
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.Count); end
      n_cmp++; if (bus.IS0_Valid !== 1'b0 || bus.IS1_Valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_valid: got %b%b want 00", bus.IS0_Valid, bus.IS1_Valid); end
      n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", bus.Stall); end
      rst = 1'b0;
      tick();                                         // accepts 4
      set_bundle(32'h200, 4'b0001, 5'd5, 5'd0, 5'd0, 5'd0);
      tick();                                         // accepts 1
      clear_bundle();
      #1;
      n_cmp++; if (bus.Count !== 5'd5) begin n_fail++; $display("FAIL fill_count: got %0d want 5", bus.Count); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d want 0", bus.Count); end
      n_cmp++; if (bus.IS0_Valid !== 1'b0 || bus.IS1_Valid !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_valid: got %b%b want 00", bus.IS0_Valid, bus.IS1_Valid); end
      n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL async_rst_stall: got %b want 0", bus.Stall); end
      #1 rst = 1'b0;
   endtask

   task automatic test_pack();
      set_bundle(32'h1000, 4'b1101, 5'd3, 5'd0, 5'd5, 5'd7);
      #1;
      n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL pack_stall: got %b want 0", bus.Stall); end
      tick();
      clear_bundle();
      #1;
      n_cmp++; if (bus.Count !== 5'd3) begin n_fail++; $display("FAIL pack_count: got %0d want 3", bus.Count); end
      n_cmp++; if (bus.IS0_Valid !== 1'b1 || bus.IS1_Valid !== 1'b1) begin
         n_fail++; $display("FAIL pack_valid: got %b%b want 11", bus.IS0_Valid, bus.IS1_Valid); end
      n_cmp++; if (bus.IS0_PC !== 32'h1000 || bus.IS0_Rdst !== 5'd3) begin
         n_fail++; $display("FAIL pack_is0: got pc %h rd %0d want 1000 3", bus.IS0_PC, bus.IS0_Rdst); end
      n_cmp++; if (bus.IS1_PC !== 32'h1008 || bus.IS1_Rdst !== 5'd5) begin
         n_fail++; $display("FAIL pack_is1: got pc %h rd %0d want 1008 5", bus.IS1_PC, bus.IS1_Rdst); end
      n_cmp++; if ({bus.IS0_ALUop, bus.IS0_Src1, bus.IS0_Src2, bus.IS0_RSrc1, bus.IS0_RSrc2,
                    bus.IS0_Phydst, bus.IS0_imm} !== {f_alu(5'd3), f_s1(5'd3), f_s2(5'd3),
                    f_rs1(5'd3), f_rs2(5'd3), f_phy(5'd3), f_imm(5'd3)}) begin
         n_fail++; $display("FAIL pack_is0_fields: got %h %h %h %h %h %h %h", bus.IS0_ALUop, bus.IS0_Src1,
            bus.IS0_Src2, bus.IS0_RSrc1, bus.IS0_RSrc2, bus.IS0_Phydst, bus.IS0_imm); end
      n_cmp++; if ({bus.IS1_ALUop, bus.IS1_Src1, bus.IS1_Src2, bus.IS1_RSrc1, bus.IS1_RSrc2,
                    bus.IS1_Phydst, bus.IS1_imm} !== {f_alu(5'd5), f_s1(5'd5), f_s2(5'd5),
                    f_rs1(5'd5), f_rs2(5'd5), f_phy(5'd5), f_imm(5'd5)}) begin
         n_fail++; $display("FAIL pack_is1_fields: got %h %h %h %h %h %h %h", bus.IS1_ALUop, bus.IS1_Src1,
            bus.IS1_Src2, bus.IS1_RSrc1, bus.IS1_RSrc2, bus.IS1_Phydst, bus.IS1_imm); end
      bus.IS0_Ready = 1'b1; bus.IS1_Ready = 1'b1;
      tick();
      n_cmp++; if (bus.Count !== 5'd1 || bus.IS1_Valid !== 1'b0) begin
         n_fail++; $display("FAIL pop2_count: got %0d v1 %b want 1 0", bus.Count, bus.IS1_Valid); end
      n_cmp++; if (bus.IS0_PC !== 32'h100C || bus.IS0_Rdst !== 5'd7) begin
         n_fail++; $display("FAIL pop2_is0: got pc %h rd %0d want 100c 7", bus.IS0_PC, bus.IS0_Rdst); end
      tick();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      n_cmp++; if (bus.Count !== 5'd0 || bus.IS0_Valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_count: got %0d v0 %b want 0 0", bus.Count, bus.IS0_Valid); end
   endtask

   task automatic test_order();
      set_bundle(32'h2000, 4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
      tick();
      clear_bundle();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b1;
      tick();
      n_cmp++; if (bus.Count !== 5'd4 || bus.IS0_PC !== 32'h2000) begin
         n_fail++; $display("FAIL order_is1_only: got cnt %0d pc %h want 4 2000", bus.Count, bus.IS0_PC); end
      bus.IS0_Ready = 1'b1;
      tick();
      n_cmp++; if (bus.Count !== 5'd2) begin n_fail++; $display("FAIL order_count: got %0d want 2", bus.Count); end
      n_cmp++; if (bus.IS0_PC !== 32'h2008 || bus.IS0_Rdst !== 5'd12 || bus.IS1_PC !== 32'h200C) begin
         n_fail++; $display("FAIL order_head: got %h rd %0d %h want 2008 12 200c", bus.IS0_PC,
            bus.IS0_Rdst, bus.IS1_PC); end
      tick();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL order_drain: got %0d want 0", bus.Count); end
   endtask

   task automatic test_full();
      for (int b = 0; b < 4; b++) begin
         set_bundle(32'h3000 + 32'(16 * b), (b == 3) ? 4'b0011 : 4'b1111, 5'(4 * b),
                    5'(4 * b + 1), 5'(4 * b + 2), 5'(4 * b + 3));
         tick();
      end
      set_bundle(32'h4000, 4'b1111, 5'd20, 5'd21, 5'd22, 5'd23);
      #1;
      n_cmp++; if (bus.Count !== 5'd14 || bus.Stall !== 1'b1) begin
         n_fail++; $display("FAIL full_stall: got cnt %0d stall %b want 14 1", bus.Count, bus.Stall); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (bus.Count !== 5'd14 || bus.Stall !== 1'b1) begin
            n_fail++; $display("FAIL full_hold%0d: got cnt %0d stall %b want 14 1", i, bus.Count, bus.Stall); end
      end
      bus.IS0_Ready = 1'b1; bus.IS1_Ready = 1'b1;
      #1;
      n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL pop_no_room: got %b want 1", bus.Stall); end
      tick();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      #1;
      n_cmp++; if (bus.Count !== 5'd12 || bus.Stall !== 1'b0) begin
         n_fail++; $display("FAIL after_pop: got cnt %0d stall %b want 12 0", bus.Count, bus.Stall); end
      tick();
      n_cmp++; if (bus.Count !== 5'd16) begin n_fail++; $display("FAIL full_16: got %0d want 16", bus.Count); end
      set_bundle(32'h5000, 4'b0001, 5'd24, 5'd0, 5'd0, 5'd0);
      bus.IS0_Ready = 1'b1; bus.IS1_Ready = 1'b1;
      #1;
      n_cmp++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL full_pop2_stall: got %b want 1", bus.Stall); end
      tick();
      clear_bundle();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      #1;
      n_cmp++; if (bus.Count !== 5'd14 || bus.IS0_PC !== 32'h3010) begin
         n_fail++; $display("FAIL full_pop2: got cnt %0d pc %h want 14 3010", bus.Count, bus.IS0_PC); end
      set_bundle(32'h6000, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
      flush = 1'b1;
      #1;
      n_cmp++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.Stall); end
      tick();
      flush = 1'b0;
      clear_bundle();
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL full_flush: got %0d want 0", bus.Count); end
   endtask

   task automatic test_flush();
      set_bundle(32'h7000, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
      tick();
      tick();
      set_bundle(32'h7100, 4'b0001, 5'd9, 5'd0, 5'd0, 5'd0);
      tick();
      n_cmp++; if (bus.Count !== 5'd9) begin n_fail++; $display("FAIL flush_fill: got %0d want 9", bus.Count); end
      set_bundle(32'h7200, 4'b1111, 5'd5, 5'd6, 5'd7, 5'd8);
      bus.IS0_Ready = 1'b1; bus.IS1_Ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      clear_bundle();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      #1;
      n_cmp++; if (bus.Count !== 5'd0 || bus.IS0_Valid !== 1'b0 || bus.IS1_Valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_clear: got cnt %0d v %b%b want 0 00", bus.Count, bus.IS0_Valid,
            bus.IS1_Valid); end
      tick();
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL flush_dropped: got %0d want 0", bus.Count); end
   endtask

   task automatic test_wrap();
      int  b, n_exp, cyc;
      bit  presented, st;
      logic [31:0] base;
      base  = 32'h0000_9000;
      b     = 0;
      n_exp = 0;
      cyc   = 0;
      bus.IS0_Ready = 1'b1; bus.IS1_Ready = 1'b1;
      while (n_exp < 60 && cyc < 400) begin
         presented = (b < 20);
         if (presented) begin
            set_bundle(base + 32'(12 * b), 4'b0111, 5'(3 * b), 5'(3 * b + 1), 5'(3 * b + 2), 5'd0);
         end else begin
            clear_bundle();
         end
         #1;
         st = bus.Stall;
         if (bus.IS0_Valid) begin
            n_cmp++; if (bus.IS0_PC !== base + 32'(4 * n_exp) || bus.IS0_Rdst !== 5'(n_exp)) begin
               n_fail++; $display("FAIL wrap_is0 #%0d: got pc %h rd %0d want %h %0d", n_exp, bus.IS0_PC,
                  bus.IS0_Rdst, base + 32'(4 * n_exp), n_exp % 32); end
            n_exp++;
            if (bus.IS1_Valid) begin
               n_cmp++; if (bus.IS1_PC !== base + 32'(4 * n_exp) || bus.IS1_Rdst !== 5'(n_exp)) begin
                  n_fail++; $display("FAIL wrap_is1 #%0d: got pc %h rd %0d want %h %0d", n_exp, bus.IS1_PC,
                     bus.IS1_Rdst, base + 32'(4 * n_exp), n_exp % 32); end
               n_exp++;
            end
         end
         tick();
         if (presented && !st) b++;
         cyc++;
      end
      clear_bundle();
      bus.IS0_Ready = 1'b0; bus.IS1_Ready = 1'b0;
      n_cmp++; if (n_exp !== 60 || b !== 20) begin
         n_fail++; $display("FAIL wrap_total: got popped %0d bundles %0d want 60 20", n_exp, b); end
      #1;
      n_cmp++; if (bus.Count !== 5'd0) begin n_fail++; $display("FAIL wrap_empty: got %0d want 0", bus.Count); end
      set_bundle(32'hFFFF_FFFC, 4'b0011, 5'd1, 5'd2, 5'd0, 5'd0);
      tick();
      clear_bundle();
      n_cmp++; if (bus.Count !== 5'd2 || bus.IS0_PC !== 32'hFFFF_FFFC || bus.IS1_PC !== 32'h0) begin
         n_fail++; $display("FAIL pc_wrap: got cnt %0d %h %h want 2 fffffffc 00000000", bus.Count,
            bus.IS0_PC, bus.IS1_PC); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_pack();
      test_order();
      test_full();
      test_flush();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
